// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_e : transmitter FSM encoding (IDLE..STOP)
//   PAR_*      : parity mode codes used by the PARITY parameter
//   cnt_width  : width of a counter that must count 0..n-1
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // At least one bit so a degenerate count still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clear      : hold the count at 0 (used while no frame is on the line)
//   bit_tick   : high in the last clk cycle of each CLKS_PER_BIT-long bit
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || bit_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a synchronous FIFO: pops one byte whenever the
// FIFO is non-empty and sends it as start bit, data LSB-first, optional
// parity, and one or two stop bits.
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset (shared with FIFO)
//   fifo_empty  : FIFO empty flag, sampled only while idle
//   fifo_data   : FIFO registered read data, valid the cycle after a read
//   fifo_rd_en  : registered one-cycle read strobe per byte
//   tx          : serial line, idles high
//   busy        : high whenever the FSM is not idle
//   frame_done  : one-cycle pulse in the last cycle of the last stop bit
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_fifo_drain: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo_drain: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo_drain: CLKS_PER_BIT must be >= 2");
  end

  // One index serves both data bits and stop bits.
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic ODD_INV = (PARITY == PAR_ODD);

  tx_state_e             state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tx_q, tx_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  bit_tick;
  logic                  baud_clear;

  // The bit timer only runs while a frame is on the line, so START always
  // begins from a fresh count.
  assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH) ||
                      (state_q == ST_LOAD);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clear),
    .bit_tick(bit_tick)
  );

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    rd_en_d    = 1'b0;
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_FETCH;
          rd_en_d = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d = fifo_data;
        par_d   = (^fifo_data) ^ ODD_INV;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PAR: begin
        if (bit_tick) begin
          state_d = ST_STOP;
          idx_d   = '0;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (idx_q == LAST_STOP) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // tx is registered from the next-state view so the line never glitches.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      ST_PAR:   tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd_en_q <= 1'b0;
      tx_q    <= 1'b1;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      tx_q    <= tx_d;
      idx_q   <= idx_d;
    end
  end

  // Datapath holds no reset; it is always reloaded in LOAD before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

endmodule
